// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Nibble-serial adder/subtractor. One operand pair is accepted in IDLE, then a
//   single 4-bit full adder processes one nibble per cycle, LSB first, for
//   NIBBLES cycles. The result is then held in DONE until the consumer takes it.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand pair present on a, b, sub
//   in_ready   block can accept an operand pair (IDLE)
//   a, b       W-bit operands
//   sub        0: a+b, 1: a-b (two's complement)
//   result     W-bit sum/difference
//   carry_out  carry out of bit W-1 (for sub, 1 = no borrow)
//   overflow   signed overflow of the W-bit operation
//   out_valid  result/carry_out/overflow valid
//   out_ready  consumer takes the result
//   busy       high in RUN or DONE
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int unsigned IdxW = $clog2(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            sub_q;
  logic            carry_q;
  logic [IdxW-1:0] idx_q;
  logic [W-1:0]    result_q;
  logic            carry_out_q;
  logic            overflow_q;
  logic            out_valid_q;

  // Single shared 4-bit full adder.
  logic [IdxW+1:0] bit_base;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [4:0]      nib_sum;
  logic [3:0]      low_sum;
  logic            msb_cin;

  always_comb begin
    bit_base = {idx_q, 2'b00};
    a_nib    = a_q[bit_base +: 4];
    // Subtraction is A + ~B + 1; the +1 comes from the carry seeded with sub.
    b_nib    = b_q[bit_base +: 4] ^ {4{sub_q}};
    nib_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    // Carry into bit 3 of the nibble; on the top nibble this is the carry into bit W-1.
    low_sum  = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
    msb_cin  = low_sum[3];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            sub_q    <= sub;
            carry_q  <= sub;
            idx_q    <= '0;
            result_q <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          result_q[bit_base +: 4] <= nib_sum[3:0];
          carry_q                 <= nib_sum[4];
          if (idx_q == LastIdx) begin
            idx_q       <= '0;
            carry_out_q <= nib_sum[4];
            overflow_q  <= msb_cin ^ nib_sum[4];
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl
//   Self-checking bench for nibble_serial_add_ctrl (NIBBLES = 4, W = 16).
//   Expected results come from plain integer arithmetic on whole operands.
module tb_nibble_serial_add_ctrl;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W = 4 * NIBBLES;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc = -1;

  nibble_serial_add_ctrl #(
    .NIBBLES(NIBBLES)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model on whole operands.
  task automatic model(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_s,
                       output logic [W-1:0] r, output logic c, output logic v);
    int ua, ub, sa, sb, full, sres;
    ua = int'(op_a);
    ub = int'(op_b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    if (op_s) begin
      full = ua - ub;
      c    = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub;
      c    = (full >= 65536);
      sres = sa + sb;
    end
    r = full[W-1:0];
    v = (sres > 32767) || (sres < -32768);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_carry"}, 32'(carry_out), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  // One full transaction. hold > 0 keeps out_ready low for that many DONE cycles while
  // offering a new operand pair. chk_gap checks the accept-to-accept spacing.
  // glitch pulses rst_n low between clock edges during RUN.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_s,
                        input int hold, input bit chk_gap, input bit glitch);
    logic [W-1:0] er;
    logic         ec, ev;
    int           lat, acc;
    model(op_a, op_b, op_s, er, ec, ev);
    out_ready = (hold == 0);
    check("accept_in_ready", 32'(in_ready), 32'd1);
    a        = op_a;
    b        = op_b;
    sub      = op_s;
    in_valid = 1'b1;
    tick();
    acc = cyc;
    if (chk_gap && last_acc >= 0) check("b2b_gap", 32'(acc - last_acc), 32'd6);
    last_acc = acc;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    sub      = 1'($urandom);
    check("run_busy", 32'(busy), 32'd1);
    check("run_in_ready", 32'(in_ready), 32'd0);
    if (glitch) begin
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(NIBBLES));
    check("result", 32'(result), 32'(er));
    check("carry_out", 32'(carry_out), 32'(ec));
    check("overflow", 32'(overflow), 32'(ev));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
      sub      = 1'($urandom);
      tick();
      check("hold_result", 32'(result), 32'(er));
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("handoff_out_valid", 32'(out_valid), 32'd0);
    // in_valid may still be high here; it must not be taken on the handoff edge.
    check("handoff_busy", 32'(busy), 32'd0);
    check("idle_result_kept", 32'(result), 32'(er));
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    rst_n = 1'b1;
    tick();

    run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b1, 0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 0, 1'b0, 1'b0);

    // Backpressure, then the following pair is accepted normally.
    run_op(16'hA5A5, 16'h1111, 1'b1, 3, 1'b0, 1'b0);
    run_op(16'h0F0F, 16'hF0F0, 1'b0, 0, 1'b0, 1'b0);

    // Reset on the second RUN cycle aborts the operation.
    out_ready = 1'b1;
    a         = 16'h5555;
    b         = 16'h3333;
    sub       = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_state("mid_run_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_stale_out_valid", 32'(out_valid), 32'd0);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, 1'b0);

    // A reset pulse between edges is not seen.
    run_op(16'h1357, 16'h2468, 1'b1, 0, 1'b0, 1'b1);

    // Back-to-back random traffic with out_ready held high.
    last_acc = -1;
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0, 1'b1, 1'b0);
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 10; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(3, 0)), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit digits per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  operand pair present on a, b, sub.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 sub  input  1  0 = A+B, 1 = A-B (two's complement).
REQ-009 result  output  W  sum/difference.
REQ-010 carry_out  output  1  carry out of bit W-1; for sub, 1 = no borrow.
REQ-011 overflow  output  1  signed overflow of the W-bit operation.
REQ-012 out_valid  output  1  result, carry_out, overflow valid.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 busy  output  1  high in RUN or DONE.

Function
REQ-015 Datapath: exactly one 4-bit full adder (a4 + b4 + cin); one nibble is processed per cycle, LSB nibble first.
REQ-016 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-017 IDLE: in_ready=1; on in_valid=1, capture a, b and sub into internal registers, set carry register to sub, clear nibble counter, go to RUN.
REQ-018 RUN: adder inputs = A nibble[idx], B nibble[idx] XOR {4{sub}}, and the carry register.
- On each edge, write the 4-bit sum into result[4*idx+3:4*idx], write the adder carry into the carry register, and increment idx.
REQ-019 RUN lasts exactly NIBBLES cycles; on the edge processing idx=NIBBLES-1, go to DONE.
- On that same edge, set carry_out to the final carry and set overflow = (carry into bit W-1) XOR (carry out of bit W-1).
REQ-020 Latency: acceptance on edge T0 gives out_valid=1 after edge T0+NIBBLES (4 cycles at default).
REQ-021 DONE: out_valid=1.
- result, carry_out and overflow are held stable until out_valid AND out_ready.
- Then go to IDLE and drop out_valid on that edge.
REQ-022 in_ready=0 in RUN and DONE; in_valid is ignored there, and operand registers do not change.
- No acceptance in the same cycle as a result handoff; in_ready rises the cycle after the handoff.
REQ-023 After the handoff, result, carry_out and overflow keep their values in IDLE until the next acceptance clears the result register.
REQ-024 Input changes on a/b/sub after acceptance have no effect on the operation in flight.
REQ-025 The nibble counter is ceil(log2(NIBBLES)) bits wide and never exceeds NIBBLES-1.
REQ-026 busy = (state != IDLE); in_ready = (state == IDLE); both are combinational from state only.

Reset
REQ-027 With rst_n=0 at a rising edge, the next state is IDLE.
- result=0, carry_out=0, overflow=0, out_valid=0, busy=0, in_ready=1; counter, carry and operand registers are cleared.
REQ-028 Reset asserted in RUN or DONE aborts the operation; no out_valid pulse follows deassertion.
REQ-029 rst_n is sampled only at clk edges; a pulse between edges has no effect.

Verification
REQ-030 Add 0x1234+0x4321, sub=0 -> result 0x5555, carry_out 0, overflow 0, out_valid exactly 4 cycles after acceptance.
REQ-031 Add 0xFFFF+0x0001 -> result 0x0000, carry_out 1, overflow 0; add 0x7FFF+0x0001 -> result 0x8000, carry_out 0, overflow 1.
REQ-032 Sub 0x0000-0x0001 -> result 0xFFFF, carry_out 0, overflow 0; sub 0x8000-0x0001 -> result 0x7FFF, carry_out 1, overflow 1.
REQ-033 Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands.
- result is held and in_ready=0; the new operands are not taken.
- After out_ready=1, state returns to IDLE, then the next operands are accepted.
REQ-034 Reset mid-RUN: assert rst_n=0 on the second RUN cycle.
- Next cycle: IDLE, result 0, out_valid 0, in_ready 1.
- A following 0x0001+0x0001 gives 0x0002 with correct latency.
REQ-035 Back-to-back: 20 random add/sub pairs with out_ready tied high.
- Every result matches (a ± b) mod 2^16, and carry/overflow are checked.
- Exactly 6 cycles per transaction (accept, 4 RUN, handoff).
